apb_master_arbiter: RTL and testbench
=====================================

Name: apb_master_arbiter

Overview:
- Shares one APB master port between two requesters (index 0: AXI4-Lite bridge path; index 1: local config/debug path).
- Round-robin arbitration; drives the APB SETUP/ACCESS sequence for the granted requester.
- Returns read data and error to the winner on a one-cycle done pulse.
- Enforces a programmable PREADY timeout so a hung slave cannot lock the bus.

Parameters:
- addrWidth, 32, APB address width.
- dataWidth, 32, APB data width (multiple of 8).
- TIMEOUT, 256, ACCESS cycles without pready before forced error completion; 0 = timeout disabled.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- req  in  2  per-requester transfer request, bit i = requester i.
- req_write  in  2  per-requester write(1)/read(0).
- req_addr  in  2*addrWidth  packed addresses, requester i at [i*addrWidth +: addrWidth].
- req_wdata  in  2*dataWidth  packed write data.
- req_strb  in  2*dataWidth/8  packed write strobes.
- req_prot  in  6  packed pprot, 3 bits per requester.
- req_done  out  2  one-cycle completion pulse to requester i.
- rsp_rdata  out  dataWidth  read data, valid while req_done != 0.
- rsp_slverr  out  1  error, valid while req_done != 0.
- grant  out  2  one-hot owner of the current transfer; 0 when idle.
- psel, penable, pwrite  out  1 each  APB control.
- paddr  out  addrWidth  APB address.
- pwdata  out  dataWidth  APB write data.
- pstrb  out  dataWidth/8  APB write strobes.
- pprot  out  3  APB protection.
- pready, pslverr  in  1 each  APB slave response.
- prdata  in  dataWidth  APB read data.

Behaviour:
- Reset (rst=0, async):
  - State IDLE; all outputs 0.
  - last_served = 1, so requester 0 wins the first tie.
  - Timeout counter = 0.
  - Takes effect mid-transfer: psel/penable drop immediately, no done is issued, and the aborted transfer is lost.
- FSM states: IDLE, SETUP, ACCESS. All APB outputs are registered.
- IDLE:
  - If req != 0, select the winner: the single requester if only one; otherwise the requester != last_served.
  - Latch the winner's write/addr/wdata/strb/prot into the APB output registers; set grant; go SETUP.
  - Next cycle: psel=1, penable=0.
- SETUP: unconditional transition to ACCESS; penable=1. APB outputs are held stable.
- ACCESS, waiting:
  - Outputs held while pready=0.
  - Timeout counter increments each ACCESS cycle.
- ACCESS, completion on pready=1:
  - Next cycle: req_done[g]=1 for one cycle; rsp_rdata = prdata (0 for writes); rsp_slverr = pslverr.
  - last_served = g; counter cleared.
- ACCESS, timeout (TIMEOUT != 0, counter reaches TIMEOUT-1 with pready=0):
  - Complete as above with rsp_slverr=1, rsp_rdata=0.
  - A late pready from the slave is ignored.
- Back-to-back:
  - At completion, if the other requester's req=1, go directly to SETUP for it. psel stays 1, penable drops to 0, and there is no IDLE cycle.
  - Otherwise go IDLE: psel=0, penable=0, grant=0.
  - The completing requester's req is ignored in the completion cycle; it is not re-granted before its done pulse is seen.
- Requester contract:
  - Payload is sampled only at grant.
  - req may stay high after done for a new transfer; it competes in the next arbitration.
  - Dropping req after grant does not abort the transfer.
- Timing:
  - Minimum latency req→done = 4 cycles (IDLE sample, SETUP, ACCESS with pready=1, done).
  - pstrb is forced to 0 for reads.
- Timeout counter width: clog2(TIMEOUT+1). It saturates and does not wrap.

Test Plan:
- Single write: req=01, addr=0x100, wdata=0xA5A5_0001, strb=0xF, pready=1 on first ACCESS → psel, then penable next cycle; paddr=0x100; req_done=01 at cycle 4; rsp_slverr=0.
- Read with 3 wait states: req=10, addr=0x7FC; prdata=0x1234 with pready after 3 ACCESS cycles → penable high 4 cycles; req_done=10; rsp_rdata=0x1234.
- Simultaneous requests after reset: req=11 → requester 0 served first, then requester 1 back-to-back with no IDLE cycle. With req held 11, the grant sequence alternates 01,10,01,10.
- Slave error: pslverr=1 with pready=1 on a write → rsp_slverr=1; the other requester's next transfer reports rsp_slverr=0.
- Timeout: TIMEOUT=8, pready held 0 → done after 8 ACCESS cycles with rsp_slverr=1, rsp_rdata=0; pready pulsed afterwards → no second done.
- Reset mid-ACCESS: rst=0 during wait state → psel/penable/grant=0 asynchronously, no done. After release, a pending req=10 is granted normally.

Source files
------------

// File: rtl/apb_master_arbiter.sv
// -----------------------------------------------------------------------------
// apb_master_arbiter
//
// Shares a single APB master port between two requesters:
//   requester 0 : AXI4-Lite bridge path
//   requester 1 : local config/debug path
// Arbitration is round-robin. The granted requester's payload is captured into
// the APB output registers at grant time. The block then runs the APB
// SETUP/ACCESS sequence and returns read data and error on a one-cycle done
// pulse. A programmable PREADY timeout forces an error completion so that a
// hung slave cannot lock the bus.
//
// Requester handshake: a requester raises req[i] with its payload valid. The
// payload is sampled only in the cycle the requester is granted. req[i] may
// drop after grant without aborting the transfer. Completion is a one-cycle
// req_done[i] pulse, with rsp_rdata/rsp_slverr valid in that same cycle. If
// req[i] is still high after done, it is treated as a new request.
//
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   req[1:0]          per-requester transfer request
//   req_write[1:0]    per-requester write(1)/read(0)
//   req_addr          packed addresses, requester i at [i*addrWidth +: addrWidth]
//   req_wdata         packed write data
//   req_strb          packed write strobes
//   req_prot          packed pprot, 3 bits per requester
//   req_done[1:0]     one-cycle completion pulse to the winner
//   rsp_rdata         read data (0 for writes/timeouts), valid with req_done
//   rsp_slverr        error, valid with req_done
//   grant[1:0]        one-hot owner of the current transfer, 0 when idle
//   psel..pprot       registered APB master outputs
//   pready, pslverr, prdata   APB slave response
//   dbgState          current FSM state (0 IDLE, 1 SETUP, 2 ACCESS)
// -----------------------------------------------------------------------------
module apb_master_arbiter #(
   parameter int addrWidth = 32,
   parameter int dataWidth = 32,
   parameter int TIMEOUT   = 256
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [1:0]                 req,
   input  logic [1:0]                 req_write,
   input  logic [2*addrWidth-1:0]     req_addr,
   input  logic [2*dataWidth-1:0]     req_wdata,
   input  logic [2*dataWidth/8-1:0]   req_strb,
   input  logic [5:0]                 req_prot,
   output logic [1:0]                 req_done,
   output logic [dataWidth-1:0]       rsp_rdata,
   output logic                       rsp_slverr,
   output logic [1:0]                 grant,
   output logic                       psel,
   output logic                       penable,
   output logic                       pwrite,
   output logic [addrWidth-1:0]       paddr,
   output logic [dataWidth-1:0]       pwdata,
   output logic [dataWidth/8-1:0]     pstrb,
   output logic [2:0]                 pprot,
   input  logic                       pready,
   input  logic                       pslverr,
   input  logic [dataWidth-1:0]       prdata,
   output logic [1:0]                 dbgState
);

   localparam int strbWidth = dataWidth / 8;
   // A disabled timeout (TIMEOUT == 0) still keeps a 1-bit counter so the
   // logic below needs no special cases; timeoutEn masks it off.
   localparam int cntWidth = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
   localparam bit timeoutEn = (TIMEOUT != 0);
   localparam logic [cntWidth-1:0] cntLast = cntWidth'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
   localparam logic [cntWidth-1:0] cntMax  = {cntWidth{1'b1}};

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } stateT;

   stateT state, stateNxt;

   // Index of the requester served last; reset to 1 so requester 0 wins the
   // first tie.
   logic                lastServed, lastServedNxt;
   logic [cntWidth-1:0] timeoutCnt, cntNxt;

   logic [1:0]           reqDoneNxt;
   logic [dataWidth-1:0] rdataNxt;
   logic                 slverrNxt;
   logic [1:0]           grantNxt;
   logic                 pselNxt;
   logic                 penableNxt;
   logic                 pwriteNxt;
   logic [addrWidth-1:0] paddrNxt;
   logic [dataWidth-1:0] pwdataNxt;
   logic [strbWidth-1:0] pstrbNxt;
   logic [2:0]           pprotNxt;

   // ---------------------------------------------------------------------------
   // Arbitration and completion decode
   // ---------------------------------------------------------------------------
   logic curIdx;        // owner of the transfer in flight (grant is one-hot)
   logic winnerIdx;     // round-robin winner when starting from IDLE
   logic timeoutHit;
   logic xferDone;      // ACCESS ends this cycle (pready or timeout)
   logic backToBack;    // other requester waiting at completion
   logic launch;        // a new transfer is granted this cycle
   logic launchIdx;

   assign curIdx     = grant[1];
   assign winnerIdx  = (req == 2'b11) ? ~lastServed : req[1];
   // pready wins over a coincident timeout, so a real response is never
   // turned into a forced error.
   assign timeoutHit = timeoutEn && (timeoutCnt == cntLast) && !pready;
   assign xferDone   = (state == ACCESS) && (pready || timeoutHit);
   // Only the other requester is considered at completion; the completing
   // requester's req is ignored until it has seen its done pulse.
   assign backToBack = xferDone && req[~curIdx];
   assign launch     = ((state == IDLE) && (req != 2'b00)) || backToBack;
   assign launchIdx  = (state == IDLE) ? winnerIdx : ~curIdx;

   // Payload of the requester being launched
   logic                 selWrite;
   logic [addrWidth-1:0] selAddr;
   logic [dataWidth-1:0] selWdata;
   logic [strbWidth-1:0] selStrb;
   logic [2:0]           selProt;

   assign selWrite = launchIdx ? req_write[1] : req_write[0];
   assign selAddr  = launchIdx ? req_addr[2*addrWidth-1:addrWidth] : req_addr[addrWidth-1:0];
   assign selWdata = launchIdx ? req_wdata[2*dataWidth-1:dataWidth] : req_wdata[dataWidth-1:0];
   assign selStrb  = launchIdx ? req_strb[2*strbWidth-1:strbWidth] : req_strb[strbWidth-1:0];
   assign selProt  = launchIdx ? req_prot[5:3] : req_prot[2:0];

   // ---------------------------------------------------------------------------
   // State register (FSM state plus all registered outputs)
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         lastServed <= 1'b1;
         timeoutCnt <= '0;
         req_done   <= 2'b00;
         rsp_rdata  <= '0;
         rsp_slverr <= 1'b0;
         grant      <= 2'b00;
         psel       <= 1'b0;
         penable    <= 1'b0;
         pwrite     <= 1'b0;
         paddr      <= '0;
         pwdata     <= '0;
         pstrb      <= '0;
         pprot      <= 3'b000;
      end else begin
         state      <= stateNxt;
         lastServed <= lastServedNxt;
         timeoutCnt <= cntNxt;
         req_done   <= reqDoneNxt;
         rsp_rdata  <= rdataNxt;
         rsp_slverr <= slverrNxt;
         grant      <= grantNxt;
         psel       <= pselNxt;
         penable    <= penableNxt;
         pwrite     <= pwriteNxt;
         paddr      <= paddrNxt;
         pwdata     <= pwdataNxt;
         pstrb      <= pstrbNxt;
         pprot      <= pprotNxt;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      stateNxt = state;
      case (state)
         IDLE:    if (req != 2'b00) stateNxt = SETUP;
         SETUP:   stateNxt = ACCESS;
         ACCESS: begin
            if (xferDone) stateNxt = backToBack ? SETUP : IDLE;
         end
         default: stateNxt = IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Output logic (next values of the registered outputs)
   // ---------------------------------------------------------------------------
   always_comb begin
      // APB payload holds unless a new transfer is launched.
      pselNxt       = psel;
      penableNxt    = penable;
      pwriteNxt     = pwrite;
      paddrNxt      = paddr;
      pwdataNxt     = pwdata;
      pstrbNxt      = pstrb;
      pprotNxt      = pprot;
      grantNxt      = grant;
      // Response fields are only meaningful during the done pulse.
      reqDoneNxt    = 2'b00;
      rdataNxt      = '0;
      slverrNxt     = 1'b0;
      lastServedNxt = lastServed;
      cntNxt        = timeoutCnt;

      case (state)
         IDLE: begin
            pselNxt    = 1'b0;
            penableNxt = 1'b0;
            grantNxt   = 2'b00;
         end
         SETUP: begin
            penableNxt = 1'b1;
         end
         ACCESS: begin
            if (xferDone) begin
               reqDoneNxt    = curIdx ? 2'b10 : 2'b01;
               // A timeout reports an error with no data, and any late pready
               // is ignored because the FSM has already left ACCESS.
               rdataNxt      = (pready && !pwrite) ? prdata : '0;
               slverrNxt     = pready ? pslverr : 1'b1;
               lastServedNxt = curIdx;
               cntNxt        = '0;
               pselNxt       = 1'b0;
               penableNxt    = 1'b0;
               grantNxt      = 2'b00;
            end else if (timeoutCnt != cntMax) begin
               cntNxt = timeoutCnt + cntWidth'(1);
            end
         end
         default: ;
      endcase

      // A launch from IDLE or back-to-back from ACCESS lands in SETUP.
      if (launch) begin
         pselNxt    = 1'b1;
         penableNxt = 1'b0;
         grantNxt   = launchIdx ? 2'b10 : 2'b01;
         pwriteNxt  = selWrite;
         paddrNxt   = selAddr;
         pwdataNxt  = selWdata;
         pstrbNxt   = selWrite ? selStrb : '0;
         pprotNxt   = selProt;
      end
   end

   assign dbgState = state;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// -----------------------------------------------------------------------------
// tb_apb_master_arbiter
//
// Directed bench for apb_master_arbiter (TIMEOUT = 8). Each response is pushed
// to expQ as {req_done, rsp_slverr, rsp_rdata} when its transfer is set up. A
// negedge monitor pops and compares one entry on every done pulse. All outputs
// are sampled on the falling edge, and inputs are driven there too.
// -----------------------------------------------------------------------------
module tb_apb_master_arbiter;

   logic        clk;
   logic        rst;
   logic [1:0]  req;
   logic [1:0]  req_write;
   logic [63:0] req_addr;
   logic [63:0] req_wdata;
   logic [7:0]  req_strb;
   logic [5:0]  req_prot;
   logic [1:0]  req_done;
   logic [31:0] rsp_rdata;
   logic        rsp_slverr;
   logic [1:0]  grant;
   logic        psel;
   logic        penable;
   logic        pwrite;
   logic [31:0] paddr;
   logic [31:0] pwdata;
   logic [3:0]  pstrb;
   logic [2:0]  pprot;
   logic        pready;
   logic        pslverr;
   logic [31:0] prdata;
   logic [1:0]  dbgState;

   int checks   = 0;
   int failures = 0;
   logic [34:0] expQ[$];

   apb_master_arbiter #(
      .addrWidth(32),
      .dataWidth(32),
      .TIMEOUT  (8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_strb  (req_strb),
      .req_prot  (req_prot),
      .req_done  (req_done),
      .rsp_rdata (rsp_rdata),
      .rsp_slverr(rsp_slverr),
      .grant     (grant),
      .psel      (psel),
      .penable   (penable),
      .pwrite    (pwrite),
      .paddr     (paddr),
      .pwdata    (pwdata),
      .pstrb     (pstrb),
      .pprot     (pprot),
      .pready    (pready),
      .pslverr   (pslverr),
      .prdata    (prdata),
      .dbgState  (dbgState)
   );

   // ---------------------------------------------------------------------------
   // Clock / reset
   // ---------------------------------------------------------------------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   // ---------------------------------------------------------------------------
   // Helpers
   // ---------------------------------------------------------------------------
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic setReq(input int idx, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] strb,
                         input logic [2:0] prot);
      if (idx == 0) begin
         req_write[0]     = wr;
         req_addr[31:0]   = addr;
         req_wdata[31:0]  = wdata;
         req_strb[3:0]    = strb;
         req_prot[2:0]    = prot;
      end else begin
         req_write[1]     = wr;
         req_addr[63:32]  = addr;
         req_wdata[63:32] = wdata;
         req_strb[7:4]    = strb;
         req_prot[5:3]    = prot;
      end
   endtask

   task automatic pushExp(input logic [1:0] done, input logic err, input logic [31:0] rd);
      expQ.push_back({done, err, rd});
   endtask

   // Called at a SETUP negedge. It runs ACCESS, raising pready once `waits`
   // ACCESS cycles have passed (waits < 0: never), and returns at the done
   // negedge. pen counts the ACCESS cycles that were seen.
   task automatic waitDone(input int waits, input logic [31:0] expAddr,
                           output int pen, output logic ok);
      pen    = 0;
      ok     = 1'b0;
      pready = 1'b0;
      for (int c = 0; c < 40; c++) begin
         tick();
         if (req_done != 2'b00) begin
            ok     = 1'b1;
            pready = 1'b0;
            break;
         end
         if (penable) begin
            pen++;
            chk("access_paddr_hold", paddr, expAddr);
            pready = (waits >= 0) && (pen > waits);
         end
      end
      if (!ok) chk("done_within_bound", {63'b0, ok}, 64'd1);
   endtask

   // ---------------------------------------------------------------------------
   // Scoreboard monitor
   // ---------------------------------------------------------------------------
   always @(negedge clk) begin
      if (req_done != 2'b00) begin
         if (expQ.size() == 0) begin
            chk("unexpected_done", {62'b0, req_done}, 64'd0);
         end else begin
            logic [34:0] e;
            e = expQ.pop_front();
            chk("response", {29'b0, req_done, rsp_slverr, rsp_rdata}, {29'b0, e});
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Directed sequence
   // ---------------------------------------------------------------------------
   initial begin
      int   pen;
      logic ok;
      logic [1:0] expGrant [4];

      rst       = 1'b0;
      req       = 2'b00;
      req_write = 2'b00;
      req_addr  = '0;
      req_wdata = '0;
      req_strb  = '0;
      req_prot  = '0;
      pready    = 1'b0;
      pslverr   = 1'b0;
      prdata    = '0;

      // Reset state
      #3;
      chk("rst_psel", psel, 0);
      chk("rst_penable", penable, 0);
      chk("rst_grant", grant, 0);
      chk("rst_done", req_done, 0);
      chk("rst_rdata", rsp_rdata, 0);
      chk("rst_slverr", rsp_slverr, 0);
      chk("rst_paddr", paddr, 0);
      chk("rst_state", dbgState, 0);
      tick();
      tick();
      rst = 1'b1;
      tick();

      // 1: single write from requester 0
      setReq(0, 1'b1, 32'h100, 32'hA5A5_0001, 4'hF, 3'b010);
      prdata = 32'hDEAD_BEEF;
      req = 2'b01;
      pushExp(2'b01, 1'b0, 32'h0);
      tick();
      chk("w_setup_psel", psel, 1);
      chk("w_setup_penable", penable, 0);
      chk("w_setup_state", dbgState, 1);
      chk("w_paddr", paddr, 32'h100);
      chk("w_pwrite", pwrite, 1);
      chk("w_pwdata", pwdata, 32'hA5A5_0001);
      chk("w_pstrb", pstrb, 4'hF);
      chk("w_pprot", pprot, 3'b010);
      chk("w_grant", grant, 2'b01);
      req = 2'b00;
      waitDone(0, 32'h100, pen, ok);
      chk("w_access_cycles", pen, 1);
      chk("w_done", req_done, 2'b01);
      chk("w_idle_psel", psel, 0);
      chk("w_idle_grant", grant, 0);

      // 2: read with 3 wait states from requester 1
      setReq(1, 1'b0, 32'h7FC, 32'h0, 4'hF, 3'b101);
      prdata = 32'h1234;
      req = 2'b10;
      pushExp(2'b10, 1'b0, 32'h1234);
      tick();
      chk("r_grant", grant, 2'b10);
      chk("r_pwrite", pwrite, 0);
      chk("r_pstrb_forced_zero", pstrb, 0);
      chk("r_pprot", pprot, 3'b101);
      req = 2'b00;
      waitDone(3, 32'h7FC, pen, ok);
      chk("r_penable_cycles", pen, 4);
      chk("r_done", req_done, 2'b10);

      // 3: simultaneous requests after reset, alternating back-to-back
      tick();
      rst = 1'b0;
      tick();
      rst = 1'b1;
      setReq(0, 1'b1, 32'h200, 32'h1111_0000, 4'h3, 3'b000);
      setReq(1, 1'b1, 32'h300, 32'h2222_0000, 4'hC, 3'b001);
      prdata = 32'hDEAD_BEEF;
      expGrant[0] = 2'b01;
      expGrant[1] = 2'b10;
      expGrant[2] = 2'b01;
      expGrant[3] = 2'b10;
      for (int k = 0; k < 4; k++) pushExp(expGrant[k], 1'b0, 32'h0);
      req = 2'b11;
      tick();
      for (int k = 0; k < 4; k++) begin
         chk("rr_grant", grant, expGrant[k]);
         chk("rr_setup_psel", psel, 1);
         chk("rr_setup_penable", penable, 0);
         chk("rr_paddr", paddr, (k % 2 == 0) ? 32'h200 : 32'h300);
         if (k == 3) req = 2'b00;
         waitDone(0, (k % 2 == 0) ? 32'h200 : 32'h300, pen, ok);
         chk("rr_done", req_done, expGrant[k]);
         chk("rr_no_idle_psel", psel, (k < 3) ? 1 : 0);
         chk("rr_penable_low", penable, 0);
      end

      // 4: slave error, then a clean transfer for the other requester
      setReq(0, 1'b1, 32'h40, 32'h0BAD_0BAD, 4'hF, 3'b000);
      pslverr = 1'b1;
      req = 2'b01;
      pushExp(2'b01, 1'b1, 32'h0);
      tick();
      req = 2'b00;
      waitDone(0, 32'h40, pen, ok);
      chk("err_slverr", rsp_slverr, 1);
      pslverr = 1'b0;
      setReq(1, 1'b0, 32'h44, 32'h0, 4'h0, 3'b000);
      prdata = 32'h55;
      req = 2'b10;
      pushExp(2'b10, 1'b0, 32'h55);
      tick();
      req = 2'b00;
      waitDone(1, 32'h44, pen, ok);
      chk("err_clear_slverr", rsp_slverr, 0);

      // 5: timeout with pready held low, then a late pready
      setReq(0, 1'b0, 32'h80, 32'h0, 4'h0, 3'b000);
      prdata = 32'hCAFE_F00D;
      req = 2'b01;
      pushExp(2'b01, 1'b1, 32'h0);
      tick();
      req = 2'b00;
      waitDone(-1, 32'h80, pen, ok);
      chk("to_access_cycles", pen, 8);
      chk("to_rdata", rsp_rdata, 0);
      pready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("to_late_no_done", req_done, 0);
         chk("to_late_psel", psel, 0);
      end
      pready = 1'b0;

      // 6: reset mid-ACCESS, then a pending request is granted normally
      setReq(0, 1'b1, 32'hC0, 32'h7777_7777, 4'hF, 3'b000);
      req = 2'b01;
      tick();
      req = 2'b00;
      tick();
      tick();
      chk("rst6_in_access", dbgState, 2);
      #2;
      rst = 1'b0;
      #1;
      chk("rst6_psel", psel, 0);
      chk("rst6_penable", penable, 0);
      chk("rst6_grant", grant, 0);
      chk("rst6_done", req_done, 0);
      tick();
      setReq(1, 1'b0, 32'hD0, 32'h0, 4'h0, 3'b011);
      prdata = 32'h600D;
      req = 2'b10;
      pushExp(2'b10, 1'b0, 32'h600D);
      tick();
      rst = 1'b1;
      tick();
      chk("rst6_regrant", grant, 2'b10);
      chk("rst6_psel_after", psel, 1);
      req = 2'b00;
      waitDone(0, 32'hD0, pen, ok);
      chk("rst6_done_after", req_done, 2'b10);

      tick();
      tick();
      chk("queue_empty", expQ.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
